// File: rtl/conv_pkg.sv
// Shared definitions for the streaming 2-D convolution engine:
// post-stage modes, arithmetic width helpers and the reset kernel.
package conv_pkg;

  typedef enum logic [1:0] {
    MODE_CLAMP = 2'b00,
    MODE_ABS   = 2'b01
  } mode_e;

  function automatic int prod_width(input int word, input int coef);
    return word + coef + 1;
  endfunction

  function automatic int sum_width(input int word, input int coef,
                                   input int kdim);
    return prod_width(word, coef) + $clog2(kdim * kdim);
  endfunction

  // Laplacian: centre tap KD^2-1, every other tap -1.
  function automatic int default_coef(input int idx, input int kdim);
    return (idx == (kdim * kdim) / 2) ? kdim * kdim - 1 : -1;
  endfunction

endpackage

// File: rtl/conv2d_stream_line_buffer.sv
// Chain of row delays addressed by column; taps[0] is one row ago,
// taps[r] is r+1 rows ago. Contents are deliberately not reset.
module line_buffer #(
  parameter int WORD_SIZE = 8,
  parameter int ROW_SIZE  = 540,
  parameter int ROWS      = 2,
  parameter int AW        = $clog2(ROW_SIZE)
) (
  input  logic                           clk,
  input  logic                           en,
  input  logic [AW-1:0]                  addr,
  input  logic [WORD_SIZE-1:0]           din,
  output logic [ROWS-1:0][WORD_SIZE-1:0] taps
);

  logic [WORD_SIZE-1:0] mem [ROWS][ROW_SIZE];

  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      taps[r] = mem[r][addr];
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      mem[0][addr] <= din;
      for (int r = 1; r < ROWS; r++) begin
        mem[r][addr] <= mem[r-1][addr];
      end
    end
  end

endmodule

// File: rtl/conv2d_stream.sv
// Streaming KxK convolution: line buffers, window, multiply, sum,
// then shift / rectify / saturate, with valid/ready back-pressure.
module conv2d_stream
  import conv_pkg::*;
#(
  parameter int WORD_SIZE  = 8,
  parameter int ROW_SIZE   = 540,
  parameter int KERNEL_DIM = 3,
  parameter int COEF_WIDTH = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic                                    in_sof,
  input  logic [WORD_SIZE-1:0]                    in_pixel,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [WORD_SIZE-1:0]                    out_pixel,
  output logic                                    out_eol,
  input  logic                                    coef_we,
  input  logic [$clog2(KERNEL_DIM*KERNEL_DIM)-1:0] coef_addr,
  input  logic [COEF_WIDTH-1:0]                   coef_data,
  input  logic [3:0]                              shift,
  input  logic [1:0]                              mode
);

  localparam int KD   = KERNEL_DIM;
  localparam int NTAP = KD * KD;
  localparam int CW   = $clog2(ROW_SIZE);
  localparam int RW   = $clog2(KD);
  localparam int PW   = prod_width(WORD_SIZE, COEF_WIDTH);
  localparam int SW   = sum_width(WORD_SIZE, COEF_WIDTH, KD);
  localparam logic signed [SW-1:0] PMAX = SW'((1 << WORD_SIZE) - 1);

  logic advance, accept, win_ok, at_eol;
  logic [CW-1:0] col, cur_col;
  logic [RW-1:0] row, cur_row;
  logic [KD-2:0][WORD_SIZE-1:0] taps;
  logic [WORD_SIZE-1:0] win [KD][KD];
  logic signed [COEF_WIDTH-1:0] coef [NTAP];
  logic signed [PW-1:0] pa [NTAP];
  logic signed [PW-1:0] cb [NTAP];
  logic signed [PW-1:0] mul [NTAP];
  logic signed [PW-1:0] prod [NTAP];
  logic signed [SW-1:0] acc, sum, sh;
  logic [WORD_SIZE-1:0] post;
  logic v1, v2, v3, e1, e2, e3;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign accept   = in_valid && advance;

  always_comb begin
    cur_col = in_sof ? '0 : col;
    cur_row = in_sof ? '0 : row;
    win_ok  = (cur_row == RW'(KD - 1)) && (cur_col >= CW'(KD - 1));
    at_eol  = (cur_col == CW'(ROW_SIZE - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (at_eol) begin
        col <= '0;
        if (cur_row != RW'(KD - 1)) row <= cur_row + 1'b1;
        else                        row <= cur_row;
      end else begin
        col <= cur_col + 1'b1;
        row <= cur_row;
      end
    end
  end

  line_buffer #(
    .WORD_SIZE(WORD_SIZE),
    .ROW_SIZE (ROW_SIZE),
    .ROWS     (KD - 1),
    .AW       (CW)
  ) u_lb (
    .clk (clk),
    .en  (accept),
    .addr(cur_col),
    .din (in_pixel),
    .taps(taps)
  );

  // Window row 0 is the oldest image row, column 0 the oldest column.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < KD; r++) begin
        for (int c = 0; c < KD - 1; c++) begin
          win[r][c] <= win[r][c+1];
        end
      end
      for (int r = 0; r < KD - 1; r++) begin
        win[r][KD-1] <= taps[KD-2-r];
      end
      win[KD-1][KD-1] <= in_pixel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NTAP; i++) begin
        coef[i] <= COEF_WIDTH'(default_coef(i, KD));
      end
    end else if (coef_we && (int'(coef_addr) < NTAP)) begin
      coef[coef_addr] <= coef_data;
    end
  end

  always_comb begin
    acc = '0;
    for (int i = 0; i < NTAP; i++) begin
      pa[i]  = {{(PW-WORD_SIZE){1'b0}}, win[i/KD][i%KD]};
      cb[i]  = {{(PW-COEF_WIDTH){coef[i][COEF_WIDTH-1]}}, coef[i]};
      mul[i] = pa[i] * cb[i];
      acc    = acc + {{(SW-PW){prod[i][PW-1]}}, prod[i]};
    end
  end

  always_comb begin
    sh = sum >>> shift;
    if ((mode == MODE_ABS) && (sh < 0)) sh = -sh;
    if (sh < 0)         post = '0;
    else if (sh > PMAX) post = '1;
    else                post = sh[WORD_SIZE-1:0];
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      for (int i = 0; i < NTAP; i++) prod[i] <= mul[i];
      sum <= acc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      {v1, v2, v3, e1, e2, e3} <= '0;
      out_valid <= 1'b0;
      out_eol   <= 1'b0;
      out_pixel <= '0;
    end else if (advance) begin
      v1        <= accept && win_ok;
      e1        <= at_eol;
      v2        <= v1;
      e2        <= e1;
      v3        <= v2;
      e3        <= e2;
      out_valid <= v3;
      out_eol   <= e3;
      out_pixel <= post;
    end
  end

endmodule

// File: doc/conv2d_stream.md
# conv2d_stream

Streaming 2-D convolution engine for the CNN image path: accepts one unsigned pixel per accepted transfer in raster order, forms a KERNEL_DIM×KERNEL_DIM window from on-chip line buffers, multiplies by a runtime-loadable signed coefficient set, and emits a shifted, rectified, saturated output pixel. It supersedes the fixed 3×3 Laplacian filter with parametrised kernel size, programmable coefficients, output scaling, frame-start alignment and valid/ready back-pressure.

## Interface
- WORD_SIZE, 8, pixel width (unsigned)
- ROW_SIZE, 540, pixels per image row
- KERNEL_DIM, 3, odd window size, ≥3
- COEF_WIDTH, 8, signed coefficient width
- clk  in  1  clock
- rst  in  1  reset; rst is synchronous, active-high; clock is clk
- in_valid  in  1  input pixel present
- in_ready  out  1  block accepts pixel this cycle
- in_sof  in  1  qualifies pixel as row 0, col 0 of a frame
- in_pixel  in  WORD_SIZE  input pixel
- out_valid  out  1  output pixel present
- out_ready  in  1  downstream accepts
- out_pixel  out  WORD_SIZE  result
- out_eol  out  1  last output of an output row
- coef_we  in  1  coefficient write strobe
- coef_addr  in  clog2(KERNEL_DIM²)  index r*KERNEL_DIM+c (r=0 oldest row, c=0 oldest column)
- coef_data  in  COEF_WIDTH  signed coefficient
- shift  in  4  arithmetic right shift applied to sum
- mode  in  2  00 clamp, 01 absolute-value then clamp, 10/11 treated as 00

## Operation
- advance = !out_valid || out_ready; in_ready = advance (combinational). Pixel accepted on in_valid && in_ready; all pipeline stages move only on advance.
- Position counters col (0..ROW_SIZE-1), row (saturating) update per accepted pixel; col wraps to 0 and row increments at ROW_SIZE-1. Pixel with in_sof forces col=0,row=0 for itself, regardless of prior position.
- Window valid when accepted pixel has row ≥ KERNEL_DIM-1 and col ≥ KERNEL_DIM-1; no border padding, no outputs for partial windows. Per frame of H rows: (ROW_SIZE-KERNEL_DIM+1)·(H-KERNEL_DIM+1) outputs.
- out_eol set on output whose window ended at col = ROW_SIZE-1.
- Arithmetic: pixel zero-extended to signed; product width PW = WORD_SIZE+COEF_WIDTH+1; sum width PW+clog2(KERNEL_DIM²), no overflow possible. result = sum >>> shift; mode 01 replaces negative result with its magnitude; then saturate to [0, 2^WORD_SIZE-1].
- Coefficient reset value: centre = KERNEL_DIM²-1, all others -1 (Laplacian). coef_we writes take effect for windows entering the multiply stage on the following cycle; independent of advance.
- shift and mode sampled at the post-processing stage; software changes them only between frames.
- in_sof mid-frame: counters restart; in-flight outputs still drain; stale line-buffer data never produces an output because of the row gate.

## Timing
- Reset: out_valid=0, out_pixel=0, out_eol=0, counters=0, coefficients to Laplacian default, stage valids cleared; in_ready=1 first cycle after reset. Line-buffer contents undefined (not reset).
- Latency: window-completing pixel accepted on advance cycle t → out_valid high after 3 further advance cycles (capture→multiply→sum→post); with out_ready held high, 3 clocks.
- Throughput: one pixel per clock with out_ready high.
- out_pixel/out_eol hold stable while out_valid && !out_ready.
- Reset mid-frame discards all in-flight data; next frame needs in_sof.

## Structure
- Package conv_pkg: mode encodings, default-coefficient function, width helper constants (PW, sum width).
- Sub-module line_buffer: KERNEL_DIM-1 row delays of ROW_SIZE, circular-addressed RAM with shift-enable; top level holds KERNEL_DIM×KERNEL_DIM window registers, counters, MAC pipeline, post stage.

## Test plan
Bench parameters ROW_SIZE=8, KERNEL_DIM=3, 6-row frames.
- Reset then idle → out_valid=0, out_pixel=0, in_ready=1; constant 10 frame, default kernel → exactly 24 outputs all 0, out_eol on every 6th.
- Single pixel 100 at (3,3), rest 0, mode 00 → output centred on it 255, its 8 neighbours 0; mode 01 → neighbours 100.
- Write centre 1, others 0 (identity) mid-idle → outputs equal input pixel at window centre, ramp image reproduced exactly.
- All coefficients 1, shift=3, constant 8 → every output 9; constant 255 → 255 (2295>>3=286, saturated).
- Random out_ready toggling and in_valid gaps on ramp image → output sequence identical to free-running run, no drops/duplicates, out_pixel stable while stalled.
- Assert rst at row 4 mid-frame, then new frame with in_sof → first output only after 2 rows + 3 pixels, count 24, no stale values.
